// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM driving datapath strobes, level selects and a retired counter.
module mc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opCode,
  input  logic [5:0]  Funct,
  input  logic        stall,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        Branch,
  output logic        Jump,
  output logic        JumpToReg,
  output logic        writeR31,
  output logic        RegDst,
  output logic        ALUSrc,
  output logic        MemtoReg,
  output logic        EXTop,
  output logic [2:0]  ALUop,
  output logic [2:0]  state,
  output logic [31:0] retired,
  output logic        illegal
);
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4} stateT;
  typedef enum logic [3:0] {cNop, cAddu, cSubu, cSll, cJr, cOri, cLui, cLw, cSw, cBeq, cJ, cJal, cIll} classT;
  stateT st, stNext;
  classT cls, decCls, curCls;
  logic [31:0] retCnt;
  logic [8:0] rawStrobe;
  logic en;
  always_comb begin
    decCls = cIll;
    case (opCode)
      6'b000000: decCls = (Funct == 6'b100001) ? cAddu :
                          (Funct == 6'b100011) ? cSubu :
                          (Funct == 6'b000000) ? cSll  :
                          (Funct == 6'b001000) ? cJr   : cIll;
      6'b001101: decCls = cOri;
      6'b001111: decCls = cLui;
      6'b100011: decCls = cLw;
      6'b101011: decCls = cSw;
      6'b000100: decCls = cBeq;
      6'b000010: decCls = cJ;
      6'b000011: decCls = cJal;
      default:   decCls = cIll;
    endcase
  end
  // DECODE sees the fresh IR; later states use the latched class so selects stay stable
  assign curCls = (st == DECODE) ? decCls : cls;
  assign RegDst = curCls inside {cAddu, cSubu, cSll};
  assign ALUSrc = curCls inside {cOri, cLui, cLw, cSw};
  assign MemtoReg = (curCls == cLw);
  assign EXTop = curCls inside {cOri, cLui};
  assign ALUop = (curCls inside {cSubu, cBeq}) ? 3'b001 :
                 (curCls == cOri) ? 3'b010 :
                 (curCls == cLui) ? 3'b011 :
                 (curCls == cSll) ? 3'b100 : 3'b000;
  // rawStrobe order: IRWrite PCWrite RegWrite MemWrite Branch Jump JumpToReg writeR31 illegal
  always_comb begin
    stNext = st;
    rawStrobe = 9'b0;
    case (st)
      FETCH: begin
        rawStrobe = 9'b1_0000_0000;
        stNext = DECODE;
      end
      DECODE: begin
        stNext = FETCH;
        case (decCls)
          cJ:      rawStrobe = 9'b0_1000_1000;
          cJal:    rawStrobe = 9'b0_1100_1010;
          cJr:     rawStrobe = 9'b0_1000_0100;
          cIll:    rawStrobe = 9'b0_1000_0001;
          default: stNext = EXEC;
        endcase
      end
      EXEC: begin
        stNext = (cls == cBeq) ? FETCH : (cls inside {cLw, cSw}) ? MEM : WB;
        rawStrobe = (cls == cBeq) ? 9'b0_1001_0000 : 9'b0;
      end
      MEM: begin
        stNext = (cls == cSw) ? FETCH : WB;
        rawStrobe = (cls == cSw) ? 9'b0_1010_0000 : 9'b0;
      end
      WB: begin
        rawStrobe = 9'b0_1100_0000;
        stNext = FETCH;
      end
      default: stNext = FETCH;
    endcase
  end
  assign en = !stall && !reset;
  assign {IRWrite, PCWrite, RegWrite, MemWrite, Branch, Jump, JumpToReg, writeR31, illegal} = rawStrobe & {9{en}};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st <= FETCH;
      cls <= cNop;
      retCnt <= 32'd0;
    end else if (!stall) begin
      st <= stNext;
      if (st == DECODE) cls <= decCls;
      if (PCWrite) retCnt <= retCnt + 32'd1;
    end
  end
  assign state = st;
  assign retired = retCnt;
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: scoreboard bench for mc_ctrl; per-instruction expected cycle sequences are queued then checked.
module tb_mc_ctrl;
  logic clk = 0, reset = 1, stall = 0;
  logic [5:0] opCode = 6'b000000, Funct = 6'b100001;
  logic IRWrite, PCWrite, RegWrite, MemWrite, Branch, Jump, JumpToReg, writeR31;
  logic RegDst, ALUSrc, MemtoReg, EXTop, illegal;
  logic [2:0] ALUop, state;
  logic [31:0] retired;

  mc_ctrl dut (
    .clk(clk), .reset(reset), .opCode(opCode), .Funct(Funct), .stall(stall),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .Branch(Branch), .Jump(Jump), .JumpToReg(JumpToReg), .writeR31(writeR31),
    .RegDst(RegDst), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .EXTop(EXTop),
    .ALUop(ALUop), .state(state), .retired(retired), .illegal(illegal)
  );

  always #5 clk = ~clk;

  localparam logic [8:0] IRW = 9'h100, PCW = 9'h080, RW = 9'h040, MW = 9'h020, BR = 9'h010;
  localparam logic [8:0] JP = 9'h008, JRS = 9'h004, R31 = 9'h002, ILL = 9'h001;

  typedef struct packed {
    logic        stl;
    logic [2:0]  st;
    logic [8:0]  sb;
    logic [6:0]  lv;
    logic [31:0] ret;
  } expT;

  expT sbq[$];
  int total = 0, bad = 0;
  logic [31:0] expRet = 0;
  logic [6:0] prevLv = 0;

  function automatic logic [8:0] strobesNow();
    return {IRWrite, PCWrite, RegWrite, MemWrite, Branch, Jump, JumpToReg, writeR31, illegal};
  endfunction

  // {RegDst, ALUSrc, MemtoReg, EXTop, ALUop}
  function automatic logic [6:0] lvOf(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'b000000 && fn == 6'b100001) return 7'b1000_000;
    if (op == 6'b000000 && fn == 6'b100011) return 7'b1000_001;
    if (op == 6'b000000 && fn == 6'b000000) return 7'b1000_100;
    if (op == 6'b001101) return 7'b0101_010;
    if (op == 6'b001111) return 7'b0101_011;
    if (op == 6'b100011) return 7'b0110_000;
    if (op == 6'b101011) return 7'b0100_000;
    if (op == 6'b000100) return 7'b0000_001;
    return 7'b0000_000;
  endfunction

  function automatic logic isLegal(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'b000000) return fn inside {6'b100001, 6'b100011, 6'b000000, 6'b001000};
    return op inside {6'b001101, 6'b001111, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b000011};
  endfunction

  task automatic doInstr(input logic [5:0] op, input logic [5:0] fn, input logic [2:0] stallSt,
                         input int stallN, input string name);
    logic [6:0] lv;
    logic [2:0] sts[$];
    logic [8:0] sbs[$];
    expT e;
    int i;
    lv = lvOf(op, fn);
    sts.push_back(3'd0); sbs.push_back(IRW);
    sts.push_back(3'd1);
    if (op == 6'b000010) sbs.push_back(JP | PCW);
    else if (op == 6'b000011) sbs.push_back(JP | RW | R31 | PCW);
    else if (op == 6'b000000 && fn == 6'b001000) sbs.push_back(JRS | PCW);
    else if (!isLegal(op, fn)) sbs.push_back(ILL | PCW);
    else begin
      sbs.push_back(9'h0);
      if (op == 6'b000100) begin sts.push_back(3'd2); sbs.push_back(BR | PCW); end
      else if (op == 6'b100011) begin
        sts.push_back(3'd2); sbs.push_back(9'h0);
        sts.push_back(3'd3); sbs.push_back(9'h0);
        sts.push_back(3'd4); sbs.push_back(RW | PCW);
      end else if (op == 6'b101011) begin
        sts.push_back(3'd2); sbs.push_back(9'h0);
        sts.push_back(3'd3); sbs.push_back(MW | PCW);
      end else begin
        sts.push_back(3'd2); sbs.push_back(9'h0);
        sts.push_back(3'd4); sbs.push_back(RW | PCW);
      end
    end
    for (int k = 0; k < sts.size(); k++) begin
      e.st = sts[k];
      e.lv = (sts[k] == 3'd0) ? prevLv : lv;
      e.ret = expRet;
      if (sts[k] == stallSt) begin
        e.stl = 1'b1; e.sb = 9'h0;
        for (int s = 0; s < stallN; s++) sbq.push_back(e);
      end
      e.stl = 1'b0; e.sb = sbs[k];
      sbq.push_back(e);
    end
    expRet = expRet + 32'd1;
    prevLv = lv;
    i = 0;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      @(negedge clk);
      stall = e.stl;
      if (i == 0) begin opCode = op; Funct = fn; end
      #1;
      total++;
      if (state !== e.st) begin bad++; $display("FAIL %s state cyc%0d got=%0d exp=%0d", name, i, state, e.st); end
      total++;
      if (strobesNow() !== e.sb) begin bad++; $display("FAIL %s strobes cyc%0d got=%b exp=%b", name, i, strobesNow(), e.sb); end
      total++;
      if ({RegDst, ALUSrc, MemtoReg, EXTop, ALUop} !== e.lv) begin
        bad++; $display("FAIL %s levels cyc%0d got=%b exp=%b", name, i, {RegDst, ALUSrc, MemtoReg, EXTop, ALUop}, e.lv);
      end
      total++;
      if (retired !== e.ret) begin bad++; $display("FAIL %s retired cyc%0d got=%h exp=%h", name, i, retired, e.ret); end
      i++;
    end
    stall = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) begin
      @(negedge clk); #1;
      total++;
      if ({state, strobesNow(), retired} !== {3'd0, 9'h0, 32'd0}) begin
        bad++; $display("FAIL reset_hold got st=%0d sb=%b ret=%h exp st=0 sb=0 ret=0", state, strobesNow(), retired);
      end
    end
    @(posedge clk); #1 reset = 1'b0;
    expRet = 0; prevLv = 0;
    doInstr(6'b000000, 6'b100001, 3'd7, 0, "addu");
  endtask

  task automatic test_load_store();
    doInstr(6'b100011, 6'b000000, 3'd7, 0, "lw");
    doInstr(6'b101011, 6'b000000, 3'd7, 0, "sw");
  endtask

  task automatic test_jumps();
    doInstr(6'b000011, 6'b000000, 3'd7, 0, "jal");
    doInstr(6'b000000, 6'b001000, 3'd7, 0, "jr");
    doInstr(6'b000010, 6'b000000, 3'd7, 0, "j");
  endtask

  task automatic test_alu_branch();
    doInstr(6'b000100, 6'b000000, 3'd7, 0, "beq");
    doInstr(6'b001101, 6'b000000, 3'd7, 0, "ori");
    doInstr(6'b111111, 6'b000000, 3'd7, 0, "illop");
    doInstr(6'b001111, 6'b000000, 3'd7, 0, "lui");
    doInstr(6'b000000, 6'b100011, 3'd7, 0, "subu");
    doInstr(6'b000000, 6'b000000, 3'd7, 0, "nop_sll");
    doInstr(6'b000000, 6'b111111, 3'd7, 0, "illfunct");
  endtask

  task automatic test_stall();
    doInstr(6'b101011, 6'b000000, 3'd3, 3, "sw_stall_mem");
    doInstr(6'b100011, 6'b000000, 3'd1, 2, "lw_stall_dec");
    doInstr(6'b000011, 6'b000000, 3'd0, 1, "jal_stall_fetch");
  endtask

  task automatic test_reset_abort();
    @(negedge clk); opCode = 6'b100011; Funct = 6'b000000; #1;
    total++;
    if ({state, strobesNow()} !== {3'd0, IRW}) begin bad++; $display("FAIL abort_fetch got st=%0d sb=%b exp st=0 sb=%b", state, strobesNow(), IRW); end
    @(negedge clk); #1;
    total++;
    if (state !== 3'd1) begin bad++; $display("FAIL abort_decode got=%0d exp=1", state); end
    @(negedge clk); #1;
    total++;
    if ({state, RegWrite, retired} !== {3'd2, 1'b0, expRet}) begin
      bad++; $display("FAIL abort_exec got st=%0d rw=%b ret=%h exp st=2 rw=0 ret=%h", state, RegWrite, retired, expRet);
    end
    reset = 1'b1; #1;
    total++;
    if ({state, strobesNow(), retired} !== {3'd0, 9'h0, 32'd0}) begin
      bad++; $display("FAIL abort_async got st=%0d sb=%b ret=%h exp st=0 sb=0 ret=0", state, strobesNow(), retired);
    end
    repeat (2) begin
      @(negedge clk); #1;
      total++;
      if ({state, RegWrite, PCWrite} !== {3'd0, 1'b0, 1'b0}) begin
        bad++; $display("FAIL abort_hold got st=%0d rw=%b pcw=%b exp st=0 rw=0 pcw=0", state, RegWrite, PCWrite);
      end
    end
    @(posedge clk); #1 reset = 1'b0;
    expRet = 0; prevLv = 0;
    doInstr(6'b000000, 6'b100001, 3'd7, 0, "addu_after_abort");
  endtask

  task automatic test_wrap();
    @(posedge clk); #1;
    force dut.retCnt = 32'hFFFF_FFFF;
    #1 release dut.retCnt;
    expRet = 32'hFFFF_FFFF;
    doInstr(6'b000010, 6'b000000, 3'd7, 0, "j_wrap");
    @(negedge clk); #1;
    total++;
    if (retired !== 32'd0) begin bad++; $display("FAIL wrap got=%h exp=00000000", retired); end
  endtask

  initial begin
    test_reset();
    test_load_store();
    test_jumps();
    test_alu_branch();
    test_stall();
    test_reset_abort();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control unit that sits directly upstream of the MIPS datapath and drives all of its control inputs. It splits each instruction into FETCH/DECODE/EXEC/MEM/WB states, strobing architectural writes only in the final cycle of each instruction. It also produces the PC and IR write enables and keeps a retired-instruction counter. It takes `opCode`/`Funct` back from the datapath's instruction register.

## Interface
- No parameters.
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high.
- `opCode` in 6: instruction[31:26] from the IR, valid from DECODE onward.
- `Funct` in 6: instruction[5:0] from the IR.
- `stall` in 1: memory not ready. Freezes the FSM and forces all strobes to 0.
- `IRWrite`, `PCWrite` out 1: IR load and PC update strobes.
- `RegWrite`, `MemWrite`, `Branch`, `Jump`, `JumpToReg`, `writeR31` out 1: datapath strobes.
- `RegDst`, `ALUSrc`, `MemtoReg`, `EXTop` out 1: level selects. `EXTop=1` means zero-extend.
- `ALUop` out 3: 000 add, 001 sub, 010 or, 011 lui (B<<16), 100 sll (by `s`).
- `state` out 3: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- `retired` out 32: count of completed instructions.
- `illegal` out 1: one-cycle pulse when DECODE sees an unsupported encoding.

## Operation
- Supported encodings:
  - R-type (op 000000) with funct 100001 addu, 100011 subu, 000000 sll, 001000 jr.
  - ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
- DECODE latches a 4-bit instruction class register.
- Level selects are decoded from the latched class and stay stable from EXEC until the next DECODE.
  - DECODE also drives them, decoded directly from the inputs.
  - RegDst=1 for addu/subu/sll.
  - ALUSrc=1 for ori/lui/lw/sw.
  - MemtoReg=1 for lw.
  - EXTop=1 for ori/lui.
  - ALUop: sub for subu/beq, or for ori, lui for lui, sll for sll, add otherwise.
- State transitions and strobes:
  - FETCH: IRWrite=1, go to DECODE.
  - DECODE, j: Jump=1, PCWrite=1, go to FETCH.
  - DECODE, jal: Jump=1, RegWrite=1, writeR31=1, PCWrite=1, go to FETCH.
  - DECODE, jr: JumpToReg=1, PCWrite=1, go to FETCH.
  - DECODE, unsupported encoding: PCWrite=1 (executes as nop), illegal=1, go to FETCH.
  - DECODE, all other instructions: go to EXEC.
  - EXEC, beq: Branch=1, PCWrite=1, go to FETCH.
  - EXEC, lw/sw: go to MEM.
  - EXEC, other instructions: go to WB.
  - MEM, sw: MemWrite=1, PCWrite=1, go to FETCH.
  - MEM, lw: go to WB.
  - WB: RegWrite=1, PCWrite=1, go to FETCH.
- Every instruction asserts PCWrite exactly once, in its last cycle.
- `retired` increments on each cycle where PCWrite=1. It wraps 0xFFFFFFFF→0.
- sll with all-zero fields (nop) is a normal 4-cycle R-type and writes $0. The GRF ignores that write.

## Timing
- Strobes are Moore outputs of (state, class). DECODE strobes are decoded combinationally from `opCode`/`Funct`.
- Instruction latencies: j/jal/jr/illegal 2 cycles; beq 3; addu/subu/sll/ori/lui/sw 4; lw 5.
- Reset behaviour:
  - While `reset`=1: state=FETCH, class=nop, retired=0, illegal=0, and every strobe is 0 (IRWrite is gated by reset).
  - The first rising edge after release has IRWrite=1 and loads the IR.
  - Reset asserted mid-instruction aborts it immediately, with no partial writes after assertion.
- Stall behaviour:
  - `stall`=1: state, class and `retired` hold. All strobes (IRWrite, PCWrite, RegWrite, MemWrite, Branch, Jump, JumpToReg, writeR31, illegal) are 0. Level selects hold.
  - `stall` falling: the FSM resumes in the same state and asserts that state's strobes.
- `illegal` is never asserted at the same time as `stall` or `reset`.

## Test plan
- Reset then release; IR holds addu $3,$1,$2 -> state 0→1→2→4→0. RegWrite=1 only in WB with RegDst=1, ALUop=000. `retired`=1 after 4 cycles.
- lw followed by sw -> lw takes 5 cycles with MemtoReg=1 in WB. sw asserts MemWrite=1 only in MEM. `retired`=2 after 9 cycles. MemWrite is never asserted during lw.
- jal, then jr -> jal sets Jump=1, RegWrite=1, writeR31=1, PCWrite=1 in DECODE (cycle 2). jr sets JumpToReg=1 in DECODE. Each takes 2 cycles.
- beq, then ori -> beq sets Branch=1, PCWrite=1, ALUop=001 in EXEC. ori has EXTop=1, ALUSrc=1, ALUop=010. Illegal opcode 111111 -> illegal pulses for 1 cycle, 2-cycle nop, `retired`+1.
- `stall`=1 for 3 cycles in MEM of sw -> state holds at 3 with MemWrite=0. After release, MemWrite=1 for exactly one cycle. Reset asserted in EXEC of lw -> state=0 and RegWrite is never asserted.
- Preload `retired` near wrap via 2^32 force or backdoor at 0xFFFFFFFF, then run one j -> `retired`=0.
